// File: rtl/jpeg_quantize_array_if.sv
// Block-level bus for the JPEG quantiser: one start request carrying a full
// 8x8 coefficient block in, one done pulse with the quantised block out.
interface jpeg_quantize_array_if;
    logic          start;
    logic [2047:0] pixels;
    logic [1023:0] q_result;
    logic          done;

    // Producer side (DCT stage / bench)
    modport master (
        output start,
        output pixels,
        input  q_result,
        input  done
    );

    // Quantiser side
    modport slave (
        input  start,
        input  pixels,
        output q_result,
        output done
    );
endinterface

// File: rtl/jpeg_quantize_array.sv
// JPEG quantisation of one 8x8 block of signed Q16.16 DCT coefficients.
// Each coefficient is multiplied by a fixed-point reciprocal of its Annex K
// table entry, rounded half away from zero and saturated to 16 bits.
// One element is processed per cycle in row-major order.
module jpeg_quantize_array #(
    parameter bit USE_LUMA = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,   // active-high despite the name
    jpeg_quantize_array_if.slave  bus
);

    // Annex K quantisation tables, row-major
    localparam int LUMA_Q [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    localparam int CHROMA_Q [64] = '{
        17,  18,  24,  47,  99,  99,  99,  99,
        18,  21,  26,  66,  99,  99,  99,  99,
        24,  26,  56,  99,  99,  99,  99,  99,
        47,  66,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99,
        99,  99,  99,  99,  99,  99,  99,  99
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [2047:0]  r_pixels;
    logic [5:0]     r_idx;
    logic           r_done;

    logic           w_load;
    logic           w_write;
    logic           w_done_next;

    logic [16:0]    w_recip [64];
    logic [16:0]    w_recip_sel;
    logic signed [31:0] w_pix;
    logic signed [49:0] w_prod;
    logic [49:0]    w_mag;
    logic [49:0]    w_rnd;
    logic [49:0]    w_qmag;
    logic [15:0]    w_q;

    // Reciprocal ROM: round(65536 / Q) folded to constants at elaboration
    for (genvar gi = 0; gi < 64; gi++) begin : g_recip
        localparam int QV = USE_LUMA ? LUMA_Q[gi] : CHROMA_Q[gi];
        localparam int RV = (2 * 65536 + QV) / (2 * QV);
        assign w_recip[gi] = 17'(RV);
    end

    // Element datapath: multiply, round half away from zero, saturate
    always_comb begin
        w_pix       = r_pixels[{r_idx, 5'b0} +: 32];
        w_recip_sel = w_recip[r_idx];
        w_prod      = w_pix * signed'({1'b0, w_recip_sel});
        w_mag       = w_prod[49] ? 50'(-w_prod) : 50'(w_prod);
        w_rnd       = w_mag + 50'h0_0000_8000_0000;
        w_qmag      = w_rnd >> 32;
        if (!w_prod[49]) begin
            w_q = (w_qmag > 50'd32767) ? 16'h7FFF : w_qmag[15:0];
        end else begin
            w_q = (w_qmag > 50'd32768) ? 16'h8000 : 16'(~w_qmag[15:0] + 16'd1);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_write      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_write = 1'b1;
                if (r_idx == 6'd63) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done_next  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture register, element index and registered done pulse
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pixels <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_load) begin
                r_pixels <= bus.pixels;
                r_idx    <= '0;
            end else if (w_write) begin
                r_idx    <= r_idx + 6'd1;
            end
        end
    end

    // Output element registers; only the element at r_idx is rewritten
    for (genvar gi = 0; gi < 64; gi++) begin : g_elem
        logic [15:0] r_elem;

        // Write element gi when the RUN index reaches it
        always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
                r_elem <= '0;
            end else if (w_write && (r_idx == 6'(gi))) begin
                r_elem <= w_q;
            end
        end

        assign bus.q_result[gi*16 +: 16] = r_elem;
    end

    assign bus.done = r_done;

endmodule

// File: tb/tb_jpeg_quantize_array.sv
// Directed and random bench for jpeg_quantize_array: both tables are
// instantiated side by side and fed the same blocks.
module tb_jpeg_quantize_array;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tb_start;
    logic [2047:0] tb_pixels;

    int errors = 0;
    int checks = 0;

    logic [31:0] pix_arr [64];

    localparam int TB_LQ [64] = '{
        16,11,10,16,24,40,51,61,  12,12,14,19,26,58,60,55,
        14,13,16,24,40,57,69,56,  14,17,22,29,51,87,80,62,
        18,22,37,56,68,109,103,77, 24,35,55,64,81,104,113,92,
        49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99
    };
    localparam int TB_CQ [64] = '{
        17,18,24,47,99,99,99,99,  18,21,26,66,99,99,99,99,
        24,26,56,99,99,99,99,99,  47,66,99,99,99,99,99,99,
        99,99,99,99,99,99,99,99,  99,99,99,99,99,99,99,99,
        99,99,99,99,99,99,99,99,  99,99,99,99,99,99,99,99
    };

    always #5 clk = ~clk;

    jpeg_quantize_array_if bus_l ();
    jpeg_quantize_array_if bus_c ();

    assign bus_l.start  = tb_start;
    assign bus_l.pixels = tb_pixels;
    assign bus_c.start  = tb_start;
    assign bus_c.pixels = tb_pixels;

    jpeg_quantize_array #(.USE_LUMA(1'b1)) dut_luma (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    jpeg_quantize_array #(.USE_LUMA(1'b0)) dut_chroma (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    // Reference formula: reciprocal rounded to nearest, product rounded half
    // away from zero at 2^32, saturated to int16.
    function automatic logic [15:0] model(input logic signed [31:0] pix, input int q);
        longint r;
        longint p;
        longint m;
        longint qq;
        r  = longint'($rtoi(65536.0 / q + 0.5));
        p  = longint'(pix) * r;
        m  = (p < 0) ? -p : p;
        qq = (m + 64'sh8000_0000) >>> 32;
        if (p < 0) qq = -qq;
        if (qq > 32767)  qq = 32767;
        if (qq < -32768) qq = -32768;
        return 16'(qq);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input logic [1023:0] vec);
        int nz;
        nz = 0;
        for (int i = 0; i < 64; i++) if (vec[i*16 +: 16] !== 16'h0000) nz++;
        checks++;
        assert (vec === '0) else begin
            errors++;
            $error("FAIL %s: got %0d nonzero elements expected 0", tag, nz);
        end
    endtask

    task automatic chk_block(input string tag, input logic [1023:0] obs, input bit luma);
        logic [1023:0] exp;
        int bad;
        for (int i = 0; i < 64; i++)
            exp[i*16 +: 16] = model(pix_arr[i], luma ? TB_LQ[i] : TB_CQ[i]);
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int i = 63; i >= 0; i--) if (obs[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
            $error("FAIL %s_%s: elem %0d got %h expected %h", tag, luma ? "luma" : "chroma",
                   bad, obs[bad*16 +: 16], exp[bad*16 +: 16]);
        end
    endtask

    task automatic clear_pix();
        for (int i = 0; i < 64; i++) pix_arr[i] = 32'h0;
    endtask

    // Issue one block and follow it to completion. extra_start / scribble
    // give the cycle (after the capture edge) at which a stray start is
    // raised or the pixel bus is overwritten; 0 disables.
    task automatic run_block(input string tag, input int extra_start, input int scribble);
        int first;
        int done_cnt;
        for (int i = 0; i < 64; i++) tb_pixels[i*32 +: 32] = pix_arr[i];
        tb_start = 1'b1;
        @(posedge clk);
        #1;
        tb_start = 1'b0;
        first    = 0;
        done_cnt = 0;
        for (int c = 1; c <= 66; c++) begin
            tb_start = (c == extra_start);
            if (c == scribble) begin
                for (int i = 0; i < 64; i++) tb_pixels[i*32 +: 32] = $urandom;
            end
            @(posedge clk);
            #1;
            if (bus_l.done) begin
                done_cnt++;
                if (first == 0) first = c;
            end
            if (c == 65) begin
                chk_block(tag, bus_l.q_result, 1'b1);
                chk_block(tag, bus_c.q_result, 1'b0);
                chk($sformatf("%s_chroma_done", tag), 32'(bus_c.done), 32'd1);
            end
        end
        tb_start = 1'b0;
        chk($sformatf("%s_done_latency", tag), 32'(first), 32'd65);
        chk($sformatf("%s_done_count", tag), 32'(done_cnt), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b1;
        tb_start  = 1'b0;
        tb_pixels = '0;
        clear_pix();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done_luma", 32'(bus_l.done), 32'd0);
        chk_zero("reset_q_luma", bus_l.q_result);
        chk_zero("reset_q_chroma", bus_c.q_result);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        $display("step: all-zero block");
        run_block("zero", 0, 0);
        chk_zero("zero_q_luma", bus_l.q_result);
        chk_zero("zero_q_chroma", bus_c.q_result);

        $display("step: luma +8.0 at elem 0");
        clear_pix();
        pix_arr[0] = 32'h0008_0000;
        run_block("luma_p8", 0, 0);
        chk("luma_q0_p8", 32'(bus_l.q_result[15:0]), 32'h0001);

        $display("step: luma -8.0 at elem 0");
        pix_arr[0] = 32'hFFF8_0000;
        run_block("luma_m8", 0, 0);
        chk("luma_q0_m8", 32'(bus_l.q_result[15:0]), 32'h0000_FFFF);

        $display("step: chroma +34.0 at elem 0, 99.0 at elem 63");
        clear_pix();
        pix_arr[0]  = 32'h0022_0000;
        pix_arr[63] = 32'h0063_0000;
        run_block("chroma_p34", 0, 0);
        chk("chroma_q0_p34", 32'(bus_c.q_result[15:0]), 32'h0002);
        chk("chroma_q63_p99", 32'(bus_c.q_result[1023:1008]), 32'h0001);

        $display("step: chroma -34.0 at elem 0");
        pix_arr[0] = 32'hFFDE_0000;
        run_block("chroma_m34", 0, 0);
        chk("chroma_q0_m34", 32'(bus_c.q_result[15:0]), 32'h0000_FFFE);

        $display("step: luma max at elem 2, stray start during RUN");
        clear_pix();
        pix_arr[2] = 32'h7FFF_0000;
        run_block("luma_max", 10, 0);
        chk("luma_q2_max", 32'(bus_l.q_result[47:32]), 32'h0CCD);

        $display("step: luma min at elem 2, pixels overwritten during RUN");
        pix_arr[2] = 32'h8000_0000;
        run_block("luma_min", 0, 20);
        chk("luma_q2_min", 32'(bus_l.q_result[47:32]), 32'h0000_F333);

        $display("step: reset mid-RUN");
        for (int i = 0; i < 64; i++) pix_arr[i] = $urandom;
        for (int i = 0; i < 64; i++) tb_pixels[i*32 +: 32] = pix_arr[i];
        tb_start = 1'b1;
        @(posedge clk);
        #1;
        tb_start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midrst_done_luma", 32'(bus_l.done), 32'd0);
        chk("midrst_done_chroma", 32'(bus_c.done), 32'd0);
        chk_zero("midrst_q_luma", bus_l.q_result);
        chk_zero("midrst_q_chroma", bus_c.q_result);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        run_block("post_reset", 0, 0);

        $display("step: 100 back-to-back random blocks");
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 64; i++) begin
                if (b % 2 == 0) pix_arr[i] = $urandom;
                else            pix_arr[i] = 32'($urandom_range(0, 32'h0100_0000)) - 32'h0080_0000;
            end
            run_block($sformatf("rand%0d", b), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
